// File: rtl/bka_multiword_seq.sv
// bka_multiword_seq: wide adder sequencer that reuses one external WORD_W-bit
// Brent-Kung adder, one word per cycle, LSW first, carry held in a register
// between words.
// Optional feature macro: BKA_SEQ_SUB_EN (adds a 'sub' port that turns the
// operation into A - B mod 2^W by inverting B and forcing the initial carry).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for an operation, in_ready=1, adder inputs parked at 0
// RUN   | driving word idx through the external adder, one word per cycle
// DONE  | result held on sum/cout with out_valid=1 until out_ready
module bka_multiword_seq #(
  parameter int WORD_W = 31,
  parameter int NWORDS = 4,
  localparam int W = WORD_W * NWORDS,
  localparam int IDX_W = (NWORDS > 2) ? $clog2(NWORDS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      op_a,
  input  logic [W-1:0]      op_b,
  input  logic              cin,
`ifdef BKA_SEQ_SUB_EN
  input  logic              sub,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      sum,
  output logic              cout,
  output logic [WORD_W-1:0] add_a,
  output logic [WORD_W-1:0] add_b,
  output logic              add_cin,
  input  logic [WORD_W-1:0] add_s,
  input  logic              add_cout
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  logic [1:0]        state;
  logic [IDX_W-1:0]  idx;
  logic              carry;
  logic [W-1:0]      a_reg;
  logic [W-1:0]      b_reg;
  logic              start_carry;
  logic              invert_b;
  logic [WORD_W-1:0] a_word;
  logic [WORD_W-1:0] b_word;

`ifdef BKA_SEQ_SUB_EN
  logic sub_reg;

  // Subtraction is A + ~B + 1, so the initial carry is forced high and cin ignored.
  assign start_carry = sub ? 1'b1 : cin;
  assign invert_b    = sub_reg;

  // Operation select is captured with the operands so later changes are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sub_reg <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      sub_reg <= sub;
    end
  end
`else
  assign start_carry = cin;
  assign invert_b    = 1'b0;
`endif

  // Handshake outputs derive from state; reset forces in_ready low immediately.
  assign in_ready  = (state == IDLE) && !reset;
  assign out_valid = (state == DONE);

  // Word select for the current index from the latched operands.
  always_comb begin
    a_word = '0;
    b_word = '0;
    for (int i = 0; i < NWORDS; i++) begin
      if (idx == IDX_W'(i)) begin
        a_word = a_reg[i*WORD_W +: WORD_W];
        b_word = b_reg[i*WORD_W +: WORD_W];
      end
    end
  end

  // Adder inputs are parked at zero outside RUN so the external adder stays quiet.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_word;
      add_b   = b_word ^ {WORD_W{invert_b}};
      add_cin = carry;
    end
  end

  // Sequencer: accept, walk the words LSW first, then hold the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= op_a;
            b_reg <= op_b;
            carry <= start_carry;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < NWORDS; i++) begin
            if (idx == IDX_W'(i)) begin
              sum[i*WORD_W +: WORD_W] <= add_s;
            end
          end
          carry <= add_cout;
          if (idx == LAST_IDX) begin
            cout  <= add_cout;
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
